tile_writer: RTL

TILE_WRITER -- requirements
Module: tile_writer

---
 rtl/tile_writer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/tile_writer.sv
// Tile writer: buffers 3x12-pixel output tiles in a small FIFO and writes them to
// frame memory one 12-pixel row per request, tracking the tile position within the frame.
module tile_writer #(
  parameter int TILE_COLS  = 53,
  parameter int TILE_ROWS  = 160,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [287:0] in_tile,
  output logic         in_ready,
  output logic         wr_en,
  output logic [14:0]  wr_addr,
  output logic [95:0]  wr_data,
  input  logic         wr_ready,
  output logic         frame_done,
  output logic         overflow
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int NW = $clog2(FIFO_DEPTH + 1);
  localparam int CW = (TILE_COLS > 1) ? $clog2(TILE_COLS) : 1;
  localparam int TW = (TILE_ROWS > 1) ? $clog2(TILE_ROWS) : 1;

  logic [287:0]  mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [NW-1:0] count_q, count_d;
  logic [1:0]    row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [TW-1:0] trow_q, trow_d;
  logic          frame_done_q, frame_done_d;
  logic          overflow_q, overflow_d;

  logic          full_s;
  logic          empty_s;
  logic          push_s;
  logic          wr_fire_s;
  logic          pop_s;
  logic [287:0]  head_s;
  logic [95:0]   row_data_s;
  logic [14:0]   addr_s;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    if (p == PW'(FIFO_DEPTH - 1)) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1'b1);
    end
  endfunction

  // Ready and write-request flags come only from registered occupancy
  assign full_s    = (count_q == NW'(FIFO_DEPTH));
  assign empty_s   = (count_q == {NW{1'b0}});
  assign push_s    = in_valid & ~full_s;
  assign wr_fire_s = ~empty_s & wr_ready;
  assign pop_s     = wr_fire_s & (row_q == 2'd2);

  assign head_s = mem_q[rd_ptr_q];
  assign addr_s = (15'(trow_q) * 15'd3 + 15'(row_q)) * 15'(TILE_COLS) + 15'(col_q);

  // Select the current row of the head tile
  always_comb begin
    row_data_s = 96'd0;
    case (row_q)
      2'd0:    row_data_s = head_s[287:192];
      2'd1:    row_data_s = head_s[191:96];
      2'd2:    row_data_s = head_s[95:0];
      default: row_data_s = 96'd0;
    endcase
  end

  // Next-state logic for FIFO pointers, row/column/tile-row counters and flags
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    row_d        = row_q;
    col_d        = col_q;
    trow_d       = trow_q;
    frame_done_d = 1'b0;
    overflow_d   = overflow_q | (in_valid & full_s);

    if (push_s) begin
      wr_ptr_d = ptr_next(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = ptr_next(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + NW'(1'b1);
      2'b01:   count_d = count_q - NW'(1'b1);
      default: count_d = count_q;
    endcase

    // Only completed writes advance the position; dropped tiles never touch it
    if (wr_fire_s) begin
      if (row_q == 2'd2) begin
        row_d = 2'd0;
        if (col_q == CW'(TILE_COLS - 1)) begin
          col_d = {CW{1'b0}};
          if (trow_q == TW'(TILE_ROWS - 1)) begin
            trow_d       = {TW{1'b0}};
            frame_done_d = 1'b1;
          end else begin
            trow_d = trow_q + TW'(1'b1);
          end
        end else begin
          col_d = col_q + CW'(1'b1);
        end
      end else begin
        row_d = row_q + 2'd1;
      end
    end else begin
      row_d = row_q;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q     <= {PW{1'b0}};
      rd_ptr_q     <= {PW{1'b0}};
      count_q      <= {NW{1'b0}};
      row_q        <= 2'd0;
      col_q        <= {CW{1'b0}};
      trow_q       <= {TW{1'b0}};
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      row_q        <= row_d;
      col_q        <= col_d;
      trow_q       <= trow_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
    end
  end

  // Tile storage; empty slots are never presented, so contents need no reset
  always_ff @(posedge clk) begin
    if (rst_n && push_s) begin
      mem_q[wr_ptr_q] <= in_tile;
    end
  end

  assign in_ready   = ~full_s;
  assign wr_en      = ~empty_s;
  assign wr_addr    = addr_s;
  assign wr_data    = empty_s ? 96'd0 : row_data_s;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;

endmodule
